// File: rtl/xy_stream_capture.sv
// ============================================================================
//  Module   : xy_stream_capture
//  Brief    : x/y deflection stream monitor; records dwell points into a FIFO.
//             Optional per-record start timestamp: XY_CAPTURE_TIMESTAMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xy_stream_capture #(
    parameter int CH_WIDTH    = 8,
    parameter int DWELL_MIN   = 4,
    parameter int DWELL_WIDTH = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CH_WIDTH-1:0]           x_ch,
    input  logic [CH_WIDTH-1:0]           y_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH_WIDTH-1:0]           out_x,
    output logic [CH_WIDTH-1:0]           out_y,
    output logic [DWELL_WIDTH-1:0]        out_dwell,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
`ifdef XY_CAPTURE_TIMESTAMP_EN
    ,
    output logic [31:0]                   out_ts
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DWELL_WIDTH-1:0] C_DWELL_MIN = DWELL_WIDTH'(DWELL_MIN);
    localparam logic [DWELL_WIDTH-1:0] C_DWELL_ONE = DWELL_WIDTH'(1);
    localparam logic [CNT_W-1:0]       C_FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]       C_CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]       C_PTR_ONE   = PTR_W'(1);

    // ------------------------------------------------------------------
    // Run tracker
    // ------------------------------------------------------------------
    logic [CH_WIDTH-1:0]    cur_x_q, cur_x_d;
    logic [CH_WIDTH-1:0]    cur_y_q, cur_y_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   have_cur_q, have_cur_d;
    logic                   same_point;
    logic                   push;

`ifdef XY_CAPTURE_TIMESTAMP_EN
    logic [31:0]            ts_q;
    logic [31:0]            run_ts_q, run_ts_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q     <= 32'd0;
            run_ts_q <= 32'd0;
        end else begin
            ts_q     <= ts_q + 32'd1;
            run_ts_q <= run_ts_d;
        end
    end
`endif

    assign same_point = (x_ch == cur_x_q) && (y_ch == cur_y_q);

    always_comb begin
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        dwell_d    = dwell_q;
        have_cur_d = have_cur_q;
        push       = 1'b0;
`ifdef XY_CAPTURE_TIMESTAMP_EN
        run_ts_d   = run_ts_q;
`endif
        if (enable) begin
            if (!have_cur_q || !same_point) begin
                // A run ending below the minimum is a beam transition, not a point.
                push       = have_cur_q && (dwell_q >= C_DWELL_MIN);
                cur_x_d    = x_ch;
                cur_y_d    = y_ch;
                dwell_d    = C_DWELL_ONE;
                have_cur_d = 1'b1;
`ifdef XY_CAPTURE_TIMESTAMP_EN
                run_ts_d   = ts_q;
`endif
            end else if (dwell_q != {DWELL_WIDTH{1'b1}}) begin
                dwell_d = dwell_q + C_DWELL_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            dwell_q    <= '0;
            have_cur_q <= 1'b0;
        end else begin
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            dwell_q    <= dwell_d;
            have_cur_q <= have_cur_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead record FIFO
    // ------------------------------------------------------------------
    logic [CH_WIDTH-1:0]    mem_x  [FIFO_DEPTH];
    logic [CH_WIDTH-1:0]    mem_y  [FIFO_DEPTH];
    logic [DWELL_WIDTH-1:0] mem_dw [FIFO_DEPTH];
`ifdef XY_CAPTURE_TIMESTAMP_EN
    logic [31:0]            mem_ts [FIFO_DEPTH];
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full  = (count_q == C_FULL);
    assign pop   = out_valid && out_ready;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (wr_en && !pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (pop && !wr_en) begin
            count_d = count_q - C_CNT_ONE;
        end
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x[wr_ptr_q]  <= cur_x_q;
            mem_y[wr_ptr_q]  <= cur_y_q;
            mem_dw[wr_ptr_q] <= dwell_q;
`ifdef XY_CAPTURE_TIMESTAMP_EN
            mem_ts[wr_ptr_q] <= run_ts_q;
`endif
        end
    end

    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_x     = out_valid ? mem_x[rd_ptr_q]  : '0;
    assign out_y     = out_valid ? mem_y[rd_ptr_q]  : '0;
    assign out_dwell = out_valid ? mem_dw[rd_ptr_q] : '0;
`ifdef XY_CAPTURE_TIMESTAMP_EN
    assign out_ts    = out_valid ? mem_ts[rd_ptr_q] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xy_stream_capture.sv
// ============================================================================
//  Module   : tb_xy_stream_capture
//  Brief    : Directed self-checking bench for xy_stream_capture.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xy_stream_capture;

    localparam int CH_WIDTH    = 8;
    localparam int DWELL_MIN   = 4;
    localparam int DWELL_WIDTH = 16;
    localparam int FIFO_DEPTH  = 16;

    logic                   clk;
    logic                   rst;
    logic                   enable;
    logic [CH_WIDTH-1:0]    x_ch;
    logic [CH_WIDTH-1:0]    y_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH_WIDTH-1:0]    out_x;
    logic [CH_WIDTH-1:0]    out_y;
    logic [DWELL_WIDTH-1:0] out_dwell;
    logic [4:0]             count;
    logic                   overflow;
`ifdef XY_CAPTURE_TIMESTAMP_EN
    logic [31:0]            out_ts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    xy_stream_capture #(
        .CH_WIDTH    (CH_WIDTH),
        .DWELL_MIN   (DWELL_MIN),
        .DWELL_WIDTH (DWELL_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .x_ch      (x_ch),
        .y_ch      (y_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_dwell (out_dwell),
        .count     (count),
        .overflow  (overflow)
`ifdef XY_CAPTURE_TIMESTAMP_EN
        ,
        .out_ts    (out_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d fails=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int x, input int y, input int n);
        x_ch = CH_WIDTH'(x);
        y_ch = CH_WIDTH'(y);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        out_ready = 1'b0;
        x_ch      = '0;
        y_ch      = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d valid=%b ovf=%b, want 0/0/0", count, out_valid, overflow);
        end
        n_checks++;
        if (out_x !== 8'd0 || out_y !== 8'd0 || out_dwell !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_head: x=%0d y=%0d dw=%0d, want 0/0/0", out_x, out_y, out_dwell);
        end
    endtask

    task automatic test_basic_point();
        do_reset();
        hold(10, 20, 6);
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_no_early_push: valid=%b count=%0d, want 0/0", out_valid, count);
        end
        hold(11, 20, 1);
        n_checks++;
        if (out_valid !== 1'b1 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL basic_valid: valid=%b count=%0d, want 1/1", out_valid, count);
        end
        n_checks++;
        if (out_x !== 8'd10 || out_y !== 8'd20 || out_dwell !== 16'd6) begin
            n_fail++;
            $display("FAIL basic_record: x=%0d y=%0d dw=%0d, want 10/20/6", out_x, out_y, out_dwell);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd0 || out_dwell !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_pop: valid=%b count=%0d dw=%0d, want 0/0/0", out_valid, count, out_dwell);
        end
    endtask

    task automatic test_short_run();
        do_reset();
        hold(5, 5, 3);
        hold(6, 6, 1);
        n_checks++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL short_discard: count=%0d, want 0", count);
        end
        hold(6, 6, 3);
        hold(7, 7, 1);
        n_checks++;
        if (count !== 5'd1 || out_x !== 8'd6 || out_y !== 8'd6 || out_dwell !== 16'd4) begin
            n_fail++;
            $display("FAIL short_min_run: count=%0d x=%0d y=%0d dw=%0d, want 1/6/6/4",
                     count, out_x, out_y, out_dwell);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 17; k++) hold(k, k + 100, 4);
        n_checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: count=%0d ovf=%b, want 16/0", count, overflow);
        end
        hold(17, 117, 4);
        n_checks++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: count=%0d ovf=%b, want 16/1", count, overflow);
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== CH_WIDTH'(i) || out_y !== CH_WIDTH'(i + 100)
                || out_dwell !== 16'd4) begin
                n_fail++;
                $display("FAIL ovf_pop%0d: valid=%b x=%0d y=%0d dw=%0d, want 1/%0d/%0d/4",
                         i, out_valid, out_x, out_y, out_dwell, i, i + 100);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drained: valid=%b count=%0d ovf=%b, want 0/0/1", out_valid, count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 0; k < 17; k++) hold(k + 50, k + 150, 4);
        n_checks++;
        if (count !== 5'd16) begin
            n_fail++;
            $display("FAIL fpp_full: count=%0d, want 16", count);
        end
        x_ch      = 8'd67;
        y_ch      = 8'd167;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || out_x !== 8'd51) begin
            n_fail++;
            $display("FAIL fpp_both: count=%0d ovf=%b head_x=%0d, want 16/0/51", count, overflow, out_x);
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            n_checks++;
            if (out_x !== CH_WIDTH'(i + 50) || out_y !== CH_WIDTH'(i + 150) || out_dwell !== 16'd4) begin
                n_fail++;
                $display("FAIL fpp_pop%0d: x=%0d y=%0d dw=%0d, want %0d/%0d/4",
                         i, out_x, out_y, out_dwell, i + 50, i + 150);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL fpp_drained: valid=%b count=%0d, want 0/0", out_valid, count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        hold(1, 2, 70000);
        hold(3, 4, 1);
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== 8'd1 || out_y !== 8'd2 || out_dwell !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_dwell: valid=%b x=%0d y=%0d dw=%0d, want 1/1/2/65535",
                     out_valid, out_x, out_y, out_dwell);
        end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        hold(3, 3, 4);
        enable = 1'b0;
        hold(9, 9, 5);
        enable = 1'b1;
        hold(3, 3, 4);
        hold(4, 4, 1);
        n_checks++;
        if (count !== 5'd1 || out_x !== 8'd3 || out_dwell !== 16'd8) begin
            n_fail++;
            $display("FAIL pause_dwell: count=%0d x=%0d dw=%0d, want 1/3/8", count, out_x, out_dwell);
        end
        hold(4, 4, 4);
        hold(5, 5, 2);
        n_checks++;
        if (count !== 5'd2) begin
            n_fail++;
            $display("FAIL rst_queued: count=%0d, want 2", count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_x !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_async: count=%0d valid=%b ovf=%b x=%0d, want 0/0/0/0",
                     count, out_valid, overflow, out_x);
        end
        tick();
        rst = 1'b0;
        hold(5, 5, 1);
        n_checks++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_first_sample: count=%0d, want 0", count);
        end
        hold(5, 5, 3);
        hold(6, 6, 1);
        n_checks++;
        if (count !== 5'd1 || out_x !== 8'd5 || out_dwell !== 16'd4) begin
            n_fail++;
            $display("FAIL rst_fresh_run: count=%0d x=%0d dw=%0d, want 1/5/4", count, out_x, out_dwell);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        x_ch      = '0;
        y_ch      = '0;
        test_reset();
        test_basic_point();
        test_short_run();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_enable_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xy_stream_capture.md
Name: xy_stream_capture

Overview:
- Receive-side monitor for the x/y deflection channel stream produced by the vector display core; sits in parallel with the x/y DAC drivers on the same x_ch/y_ch buses.
- Samples both channels every clock, detects each dwell point (a stable (x,y) pair) and measures its length in cycles.
- Pushes each completed point as a record into an internal show-ahead FIFO, read out through a valid/ready handshake.
- Used for on-chip loopback self-test and for dumping displayed frames to a host.

Parameters:
- CH_WIDTH, 8, width of each of x_ch and y_ch.
- DWELL_MIN, 4, minimum run length in cycles for a point to be recorded; must be 1 or more.
- DWELL_WIDTH, 16, width of the dwell counter and of the dwell field in a record.
- FIFO_DEPTH, 16, number of records held; must be a power of 2 and 2 or more.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; when low, sampling is frozen.
- x_ch  in  CH_WIDTH  x channel sample.
- y_ch  in  CH_WIDTH  y channel sample.
- out_valid  out  1  FIFO head record is valid.
- out_ready  in  1  consumer accepts the head record.
- out_x  out  CH_WIDTH  x of the head record.
- out_y  out  CH_WIDTH  y of the head record.
- out_dwell  out  DWELL_WIDTH  run length of the head record, in cycles.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a record was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, rst=1):
  - FIFO empty; count=0, out_valid=0, out_x/out_y/out_dwell=0, overflow=0.
  - cur_x=cur_y=0, dwell=0, have_cur=0.
- Sampling only happens when enable=1. With enable=0, cur/dwell/have_cur hold and no push occurs; pops still work.
- First sample after reset: cur = (x_ch,y_ch), dwell=1, have_cur=1, no push.
- Sample equal to cur: dwell increments, saturating at all-ones (no wrap).
- Sample differing from cur:
  - If dwell >= DWELL_MIN, push record {cur_x, cur_y, dwell}.
  - Then load cur = new sample, dwell=1.
  - Runs shorter than DWELL_MIN are discarded silently; they are transitions, not points.
- Push latency: the record is visible at the FIFO head on the cycle after the sample that differs (if the FIFO was empty, out_valid rises one cycle after the change).
- The current, unfinished run is never pushed; a point is recorded only when it ends.
- FIFO:
  - Show-ahead; out_* reflect the head while out_valid=1 and are driven to 0 when empty.
  - out_valid = (count != 0).
  - Pop on out_valid & out_ready; the head advances on the next clock edge.
  - out_ready while empty is ignored.
- Full:
  - Push without a pop in the same cycle drops the record and sets overflow; overflow clears only on reset.
  - Push and pop in the same cycle while full: both take effect and count stays at FIFO_DEPTH.
- Simultaneous push and pop at any other occupancy: count unchanged.
- Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; occupancy is tracked by count.

Optional Feature:
- Macro: XY_CAPTURE_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter: reset to 0, increments every clk regardless of enable, wraps.
  - Each record gains the counter value latched at the first cycle of its run.
  - Adds output port out_ts [31:0], which follows the same valid/empty rules as the other out_* fields.
- Undefined: no counter and no out_ts port; behaviour is otherwise identical.

Test Plan:
- Reset, then hold (10,20) for 6 cycles and switch to (11,20) -> one record {10,20,6}; out_valid rises the cycle after the switch; count=1.
- Hold (5,5) for 3 cycles (DWELL_MIN=4), then (6,6) for 4 cycles, then (7,7) -> only {6,6,4} recorded; (5,5) discarded.
- Hold out_ready=0 and generate 17 qualifying points -> count=16, overflow=1, and the 17th record is absent; then pop all 16 -> records come out in order and out_valid=0.
- FIFO full, produce a point change in the same cycle as out_ready=1 -> count stays 16, overflow stays 0, and the new record appears at the tail.
- Hold (1,2) for 70000 cycles with DWELL_WIDTH=16, then change -> out_dwell=65535.
- Pulse enable=0 for 5 cycles mid-run of (3,3) (run of 4 before, 4 after), then change; also assert rst mid-run with 2 records queued -> first gives record dwell=8; after the reset: count=0, out_valid=0, overflow=0, and the next run starts fresh with no push on its first sample.
